// File: rtl/i2s_tdm_timing_gen.sv
// Bit clock, frame sync and slot/bit position generator for I2S, left-justified and DSP/TDM codec links.
// Latency: strobes decode div_cnt in the same cycle; BCLK/LRC/pos update on the following clk_50m edge.
// Backpressure: none; free-running while enabled, a stop request completes at the next frame boundary.
module i2s_tdm_timing_gen #(
    parameter int SYS_CLK     = 50_000_000,
    parameter int SAMPLE_RATE = 48_000,
    parameter int SLOT_W      = 32,
    parameter int NUM_SLOTS   = 2
) (
    input  logic                         clk_50m,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    output logic                         BCLK,
    output logic                         LRC,
    output logic                         p_bclk,
    output logic                         n_bclk,
    output logic                         frame_start,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
    output logic [$clog2(SLOT_W)-1:0]    bit_idx,
    output logic                         busy
);

    localparam int FRAME = SLOT_W * NUM_SLOTS;
    localparam int DIV   = SYS_CLK / (SAMPLE_RATE * FRAME);
    localparam int DW    = $clog2(DIV);
    localparam int PW    = $clog2(FRAME);
    localparam int SIW   = $clog2(NUM_SLOTS);
    localparam int BIW   = $clog2(SLOT_W);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_FALL = DW'(DIV / 2 - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(FRAME - 1);
    localparam logic [PW-1:0] POS_HALF = PW'(FRAME / 2);
    localparam logic [PW-1:0] SLOT_LEN = PW'(SLOT_W);

    localparam logic [1:0] MODE_I2S = 2'd0;
    localparam logic [1:0] MODE_LJ  = 2'd1;
    localparam logic [1:0] MODE_DSP = 2'd2;

    // A divider below 4 cannot hold separate BCLK high/low phases; odd slot counts break the LRC halves.
    if (DIV < 4 || (NUM_SLOTS % 2) != 0) begin : g_bad_params
        $error("i2s_tdm_timing_gen: DIV must be >= 4 and NUM_SLOTS must be even");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    mode_q;
    logic [DW-1:0] div_cnt;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_next;
    logic [PW-1:0] pos_after;
    logic          lrc_next;
    logic          active;
    logic          wrap;
    logic          drain_stop;

    assign active      = (state != ST_IDLE);
    assign p_bclk      = active && (div_cnt == DIV_LAST);
    assign n_bclk      = active && (div_cnt == DIV_FALL);
    assign wrap        = n_bclk && (pos == POS_LAST);
    // A drain that is not re-armed ends on the wrap edge instead of starting a new frame.
    assign drain_stop  = wrap && (state == ST_DRAIN) && !en;
    assign frame_start = wrap && !drain_stop;
    assign busy        = active;
    assign slot_idx    = SIW'(pos / SLOT_LEN);
    assign bit_idx     = BIW'(pos % SLOT_LEN);

    // Next frame position and the word-select level that belongs to it in the latched format.
    always_comb begin
        lrc_next  = 1'b0;
        pos_next  = (pos == POS_LAST) ? '0 : pos + 1'b1;
        pos_after = (pos_next == POS_LAST) ? '0 : pos_next + 1'b1;
        case (mode_q)
            MODE_LJ:  lrc_next = (pos_next < POS_HALF);
            MODE_DSP: lrc_next = (pos_next == POS_LAST);
            default:  lrc_next = (pos_after >= POS_HALF);
        endcase
    end

    // Run/drain control, BCLK divider, frame position and registered BCLK/LRC.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_I2S;
            div_cnt <= '0;
            pos     <= POS_LAST;
            BCLK    <= 1'b0;
            LRC     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state  <= ST_RUN;
                        mode_q <= (mode == 2'd3) ? MODE_I2S : mode;
                    end
                end
                default: begin
                    if (drain_stop) begin
                        state   <= ST_IDLE;
                        div_cnt <= '0;
                        pos     <= POS_LAST;
                        BCLK    <= 1'b0;
                        LRC     <= 1'b0;
                    end else begin
                        state   <= en ? ST_RUN : ST_DRAIN;
                        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                        if (p_bclk) begin
                            BCLK <= 1'b1;
                        end
                        if (n_bclk) begin
                            BCLK <= 1'b0;
                            pos  <= pos_next;
                            LRC  <= lrc_next;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tdm_timing_gen.sv
// Directed bench for i2s_tdm_timing_gen: default 2x32 I2S instance plus an 8x16 DSP/TDM instance.
// Expected values are hand-derived frame positions, timings and word-select levels.
// Outputs are sampled on the falling clk_50m edge.
module tb_i2s_tdm_timing_gen;

    logic       clk_50m;
    logic       rst_n;
    logic       en_a, en_b;
    logic [1:0] mode_a, mode_b;

    logic       a_bclk, a_lrc, a_p, a_n, a_fs, a_busy;
    logic [0:0] a_slot;
    logic [4:0] a_bit;
    logic       b_bclk, b_lrc, b_p, b_n, b_fs, b_busy;
    logic [2:0] b_slot;
    logic [3:0] b_bit;

    int n_vec = 0;
    int n_err = 0;

    i2s_tdm_timing_gen u_dut_a (
        .clk_50m(clk_50m), .rst_n(rst_n), .en(en_a), .mode(mode_a),
        .BCLK(a_bclk), .LRC(a_lrc), .p_bclk(a_p), .n_bclk(a_n), .frame_start(a_fs),
        .slot_idx(a_slot), .bit_idx(a_bit), .busy(a_busy)
    );

    i2s_tdm_timing_gen #(
        .SYS_CLK(50_000_000), .SAMPLE_RATE(96_000), .SLOT_W(16), .NUM_SLOTS(8)
    ) u_dut_b (
        .clk_50m(clk_50m), .rst_n(rst_n), .en(en_b), .mode(mode_b),
        .BCLK(b_bclk), .LRC(b_lrc), .p_bclk(b_p), .n_bclk(b_n), .frame_start(b_fs),
        .slot_idx(b_slot), .bit_idx(b_bit), .busy(b_busy)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    initial begin
        #1_600_000;
        $display("FAIL watchdog: simulation did not complete (vectors %0d, miscompares %0d)", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, required %0d", tag, got, exp);
        end
    endtask

    function automatic int n_of(input bit sel);    return sel ? int'(b_n)    : int'(a_n);    endfunction
    function automatic int p_of(input bit sel);    return sel ? int'(b_p)    : int'(a_p);    endfunction
    function automatic int fs_of(input bit sel);   return sel ? int'(b_fs)   : int'(a_fs);   endfunction
    function automatic int busy_of(input bit sel); return sel ? int'(b_busy) : int'(a_busy); endfunction
    function automatic int bclk_of(input bit sel); return sel ? int'(b_bclk) : int'(a_bclk); endfunction
    function automatic int lrc_of(input bit sel);  return sel ? int'(b_lrc)  : int'(a_lrc);  endfunction
    function automatic int slot_of(input bit sel); return sel ? int'(b_slot) : int'(a_slot); endfunction
    function automatic int bit_of(input bit sel);  return sel ? int'(b_bit)  : int'(a_bit);  endfunction

    // Waits for frame_start, then steps to the cycle where pos reads 0.
    task automatic wait_fs(input bit sel, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 1300; i++) begin
            if (fs_of(sel) != 0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_50m);
        end
        check_vec({tag, "_fs_seen"}, int'(found), 1);
        @(negedge clk_50m);
    endtask

    // Waits for the next n_bclk, then steps to the cycle where pos has advanced.
    task automatic next_pos(input bit sel, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (n_of(sel) != 0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_50m);
        end
        if (!found) check_vec({tag, "_nbclk_seen"}, 0, 1);
        @(negedge clk_50m);
    endtask

    task automatic wait_idle(input bit sel, input string tag);
        for (int i = 0; i < 1300; i++) begin
            if (busy_of(sel) == 0) break;
            @(negedge clk_50m);
        end
        check_vec({tag, "_idle"}, busy_of(sel), 0);
    endtask

    // Called on the falling edge where en has just been raised from IDLE.
    task automatic start_timing(input string tag);
        int first_n, first_p, first_hi, fs_at_n, busy1;
        first_n = -1; first_p = -1; first_hi = -1; fs_at_n = 0; busy1 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_50m);
            if (c == 1) busy1 = int'(a_busy);
            if (a_n && first_n < 0) begin
                first_n = c;
                fs_at_n = int'(a_fs);
            end
            if (a_p && first_p < 0) first_p = c;
            if (a_bclk && first_hi < 0) first_hi = c;
        end
        check_vec({tag, "_busy"}, busy1, 1);
        check_vec({tag, "_first_nbclk"}, first_n, 8);
        check_vec({tag, "_fs_at_first_n"}, fs_at_n, 1);
        check_vec({tag, "_first_pbclk"}, first_p, 16);
        check_vec({tag, "_first_bclk_hi"}, first_hi, 17);
    endtask

    // One full frame: LRC, slot and bit at every position p.
    task automatic sweep(input bit sel, input int m, input string tag);
        int frame, sw, exp_lrc;
        frame = sel ? 128 : 64;
        sw    = sel ? 16 : 32;
        wait_fs(sel, tag);
        for (int p = 0; p < frame; p++) begin
            if (p != 0) next_pos(sel, tag);
            case (m)
                1:       exp_lrc = (p < frame / 2) ? 1 : 0;
                2:       exp_lrc = (p == frame - 1) ? 1 : 0;
                default: exp_lrc = (((p + 1) % frame) >= frame / 2) ? 1 : 0;
            endcase
            check_vec($sformatf("%s_lrc_p%0d", tag, p), lrc_of(sel), exp_lrc);
            check_vec($sformatf("%s_slot_p%0d", tag, p), slot_of(sel), p / sw);
            check_vec($sformatf("%s_bit_p%0d", tag, p), bit_of(sel), p % sw);
        end
    endtask

    // BCLK duty over 64 cycles and the clk_50m count between frame_start pulses.
    task automatic period_check(input bit sel, input int exp_frame, input string tag);
        int cnt, hi;
        wait_fs(sel, tag);
        cnt = 1;
        hi  = 0;
        for (int i = 0; i < 1100; i++) begin
            if (fs_of(sel) != 0) break;
            if (i < 64) hi += bclk_of(sel);
            @(negedge clk_50m);
            cnt++;
        end
        check_vec({tag, "_bclk_hi_of_64"}, hi, 32);
        check_vec({tag, "_frame_clks"}, cnt, exp_frame);
    endtask

    initial begin
        int strobes, found;
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
        repeat (3) @(negedge clk_50m);

        check_vec("rst_bclk", int'(a_bclk), 0);
        check_vec("rst_lrc", int'(a_lrc), 0);
        check_vec("rst_busy", int'(a_busy), 0);
        check_vec("rst_strobes", int'(a_p) + int'(a_n) + int'(a_fs), 0);
        check_vec("rst_slot", int'(a_slot), 1);
        check_vec("rst_bit", int'(a_bit), 31);
        check_vec("rst_b_busy", int'(b_busy), 0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk_50m);
        check_vec("idle_wait_en", int'(a_busy), 0);

        en_a = 1'b1;
        start_timing("start");
        sweep(1'b0, 0, "i2s");
        period_check(1'b0, 1024, "i2s_period");

        en_a = 1'b0; wait_idle(1'b0, "stop1");
        mode_a = 2'd1; en_a = 1'b1;
        sweep(1'b0, 1, "lj");
        mode_a = 2'd2;
        sweep(1'b0, 1, "lj_hold");

        en_a = 1'b0; wait_idle(1'b0, "stop2");
        mode_a = 2'd2; en_a = 1'b1;
        sweep(1'b0, 2, "dsp");

        en_a = 1'b0; wait_idle(1'b0, "stop3");
        mode_a = 2'd3; en_a = 1'b1;
        sweep(1'b0, 0, "rsvd");

        en_a = 1'b0; wait_idle(1'b0, "stop4");
        mode_a = 2'd0; en_a = 1'b1;
        wait_fs(1'b0, "drain");
        repeat (10) next_pos(1'b0, "drain");
        en_a = 1'b0;
        repeat (53) next_pos(1'b0, "drain");
        check_vec("drain_busy_pos63", int'(a_busy), 1);
        check_vec("drain_bit_pos63", int'(a_bit), 31);
        found = 0;
        for (int i = 0; i < 32; i++) begin
            if (a_n) begin
                found = 1;
                break;
            end
            @(negedge clk_50m);
        end
        check_vec("drain_wrap_nbclk", found, 1);
        check_vec("drain_no_fs", int'(a_fs), 0);
        @(negedge clk_50m);
        check_vec("drain_end_busy", int'(a_busy), 0);
        check_vec("drain_end_bclk", int'(a_bclk), 0);
        check_vec("drain_end_lrc", int'(a_lrc), 0);
        check_vec("drain_end_bit", int'(a_bit), 31);
        strobes = 0;
        repeat (40) begin
            strobes += int'(a_p) + int'(a_n) + int'(a_fs);
            @(negedge clk_50m);
        end
        check_vec("drain_quiet", strobes, 0);

        en_a = 1'b1;
        wait_fs(1'b0, "rearm");
        repeat (10) next_pos(1'b0, "rearm");
        en_a = 1'b0;
        repeat (30) next_pos(1'b0, "rearm");
        check_vec("rearm_busy_pos40", int'(a_busy), 1);
        en_a = 1'b1;
        repeat (23) next_pos(1'b0, "rearm");
        found = 0;
        for (int i = 0; i < 32; i++) begin
            if (a_n) begin
                found = 1;
                break;
            end
            @(negedge clk_50m);
        end
        check_vec("rearm_wrap_nbclk", found, 1);
        check_vec("rearm_fs", int'(a_fs), 1);
        @(negedge clk_50m);
        check_vec("rearm_bit0", int'(a_bit), 0);
        check_vec("rearm_slot0", int'(a_slot), 0);
        check_vec("rearm_busy", int'(a_busy), 1);

        found = 0;
        for (int i = 0; i < 1100; i++) begin
            if (a_bclk && a_lrc) begin
                found = 1;
                break;
            end
            @(negedge clk_50m);
        end
        check_vec("mid_frame_bclk_lrc_hi", found, 1);
        rst_n = 1'b0;
        en_a  = 1'b0;
        @(negedge clk_50m);
        check_vec("midrst_bclk", int'(a_bclk), 0);
        check_vec("midrst_lrc", int'(a_lrc), 0);
        check_vec("midrst_busy", int'(a_busy), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50m);
        check_vec("midrst_idle_hold", int'(a_busy), 0);
        en_a = 1'b1;
        start_timing("restart");
        en_a = 1'b0; wait_idle(1'b0, "stop5");

        mode_b = 2'd2; en_b = 1'b1;
        period_check(1'b1, 512, "tdm_period");
        sweep(1'b1, 2, "tdm");
        en_b = 1'b0; wait_idle(1'b1, "tdm_stop");
        strobes = 0;
        repeat (20) begin
            strobes += p_of(1'b1) + n_of(1'b1) + fs_of(1'b1);
            @(negedge clk_50m);
        end
        check_vec("tdm_quiet", strobes, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
